// File: rtl/scaler_vline_gen_if.sv
// -----------------------------------------------------------------------------
// scaler_vline_gen_if
//   Per-line handshake between the vertical line generator and the scaler
//   read/interpolation datapath.
//
//   line_req_i        datapath -> gen   one-cycle request for the next line
//   lines_avail_i     datapath -> gen   input lines fully written this frame
//   frame_buffered_i  datapath -> gen   whole input frame present
//   line_valid_o      gen -> datapath   one-cycle strobe, line outputs valid
//   rdline_a_o        gen -> datapath   upper source line
//   rdline_b_o        gen -> datapath   lower source line
//   weight_o          gen -> datapath   blend weight toward rdline_b
//   last_line_o       gen -> datapath   qualifies the final output line
//   stall_o           gen -> datapath   waiting for rdline_b to be written
//   req_err_o         gen -> datapath   request arrived when not accepted
// -----------------------------------------------------------------------------
interface scaler_vline_gen_if #(
   parameter int WGT_W = 8
);
   logic             line_req_i;
   logic [9:0]       lines_avail_i;
   logic             frame_buffered_i;
   logic             line_valid_o;
   logic [9:0]       rdline_a_o;
   logic [9:0]       rdline_b_o;
   logic [WGT_W-1:0] weight_o;
   logic             last_line_o;
   logic             stall_o;
   logic             req_err_o;

   modport slave (
      input  line_req_i,
      input  lines_avail_i,
      input  frame_buffered_i,
      output line_valid_o,
      output rdline_a_o,
      output rdline_b_o,
      output weight_o,
      output last_line_o,
      output stall_o,
      output req_err_o
   );

   modport master (
      output line_req_i,
      output lines_avail_i,
      output frame_buffered_i,
      input  line_valid_o,
      input  rdline_a_o,
      input  rdline_b_o,
      input  weight_o,
      input  last_line_o,
      input  stall_o,
      input  req_err_o
   );
endinterface

// File: rtl/scaler_vline_gen.sv
// -----------------------------------------------------------------------------
// scaler_vline_gen
//   Vertical source-line generator for the scaler. Latches the vertical
//   scaling configuration once per output frame, then for each output line
//   request produces the two input lines to blend plus a blend weight, and
//   holds off until the line buffer contains the lower source line.
//
//   Ports
//     VCLK                video/scaler clock
//     nRST                asynchronous active-low reset
//     frame_start_i       output vsync pulse; latches config, restarts frame
//     vpos_1st_rdline_i   first input line to read
//     vlines_in_needed_i  input lines spanned by the active output
//     vlines_out_i        output active lines
//     v_interp_factor_i   floor(2^FRAC_W / vlines_out)
//     lif                 line request/response handshake (slave side)
//
// State | meaning
// ------+-----------------------------------------------------------------
// IDLE  | after reset, no frame configured; requests are errors
// PREP  | one cycle: compute step, initial position, last source line
// ACTIVE| waiting for a line request
// CHECK | computing a/b/w, waiting until rdline_b is in the line buffer
// DONE  | all output lines of the frame issued; requests are errors
// -----------------------------------------------------------------------------
module scaler_vline_gen #(
   parameter int FRAC_W = 17,
   parameter int WGT_W  = 8
) (
   input  logic                VCLK,
   input  logic                nRST,
   input  logic                frame_start_i,
   input  logic [9:0]          vpos_1st_rdline_i,
   input  logic [9:0]          vlines_in_needed_i,
   input  logic [11:0]         vlines_out_i,
   input  logic [FRAC_W:0]     v_interp_factor_i,
   scaler_vline_gen_if.slave   lif
);

   // 10 integer line bits + 1 guard bit above the fraction
   localparam int POS_W = FRAC_W + 11;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_PREP   = 3'd1,
      ST_ACTIVE = 3'd2,
      ST_CHECK  = 3'd3,
      ST_DONE   = 3'd4
   } state_t;

   state_t             state_q,       state_d;
   logic [9:0]         vpos_l_q,      vpos_l_d;
   logic [9:0]         needed_l_q,    needed_l_d;
   logic [11:0]        vout_l_q,      vout_l_d;
   logic [FRAC_W:0]    factor_l_q,    factor_l_d;
   logic [POS_W-1:0]   step_l_q,      step_l_d;
   logic [POS_W-1:0]   pos_q,         pos_d;
   logic [11:0]        line_cnt_q,    line_cnt_d;
   logic [9:0]         last_src_q,    last_src_d;
   logic               line_valid_q,  line_valid_d;
   logic [9:0]         rdline_a_q,    rdline_a_d;
   logic [9:0]         rdline_b_q,    rdline_b_d;
   logic [WGT_W-1:0]   weight_q,      weight_d;
   logic               last_line_q,   last_line_d;
   logic               stall_q,       stall_d;
   logic               req_err_q,     req_err_d;

   logic [10:0]        a_full;
   logic               a_clamped;
   logic [9:0]         a_sel;
   logic [10:0]        a_inc;
   logic [9:0]         b_sel;
   logic [WGT_W-1:0]   w_sel;
   logic               src_ready;
   logic               is_last;
   logic [POS_W-1:0]   step_prod;

   // Source-line selection from the current accumulator. The guard bit is
   // included in the clamp compare so a stray carry would still clamp.
   always_comb begin
      a_full    = pos_q[POS_W-1:FRAC_W];
      a_clamped = (a_full > {1'b0, last_src_q});
      a_sel     = a_clamped ? last_src_q : a_full[9:0];
      a_inc     = {1'b0, a_sel} + 11'd1;
      b_sel     = (a_inc > {1'b0, last_src_q}) ? last_src_q : a_inc[9:0];
      w_sel     = a_clamped ? '0 : pos_q[FRAC_W-1 -: WGT_W];
      src_ready = lif.frame_buffered_i || (b_sel < lif.lines_avail_i);
      is_last   = (line_cnt_q == (vout_l_q - 12'd1));
      step_prod = POS_W'(needed_l_q) * POS_W'(factor_l_q);
   end

   always_comb begin
      state_d      = state_q;
      vpos_l_d     = vpos_l_q;
      needed_l_d   = needed_l_q;
      vout_l_d     = vout_l_q;
      factor_l_d   = factor_l_q;
      step_l_d     = step_l_q;
      pos_d        = pos_q;
      line_cnt_d   = line_cnt_q;
      last_src_d   = last_src_q;
      rdline_a_d   = rdline_a_q;
      rdline_b_d   = rdline_b_q;
      weight_d     = weight_q;
      last_line_d  = last_line_q;
      line_valid_d = 1'b0;
      stall_d      = 1'b0;
      req_err_d    = 1'b0;

      if (frame_start_i) begin
         // frame restart wins; a coincident request is silently dropped
         vpos_l_d    = vpos_1st_rdline_i;
         needed_l_d  = vlines_in_needed_i;
         vout_l_d    = vlines_out_i;
         factor_l_d  = v_interp_factor_i;
         last_line_d = 1'b0;
         state_d     = ST_PREP;
      end else begin
         case (state_q)
            ST_PREP: begin
               req_err_d  = lif.line_req_i;
               step_l_d   = step_prod;
               pos_d      = {1'b0, vpos_l_q, {FRAC_W{1'b0}}};
               line_cnt_d = '0;
               last_src_d = (needed_l_q == 10'd0) ? vpos_l_q
                                                  : (vpos_l_q + needed_l_q - 10'd1);
               state_d    = (vout_l_q == 12'd0) ? ST_DONE : ST_ACTIVE;
            end
            ST_ACTIVE: begin
               if (lif.line_req_i) begin
                  state_d = ST_CHECK;
               end
            end
            ST_CHECK: begin
               req_err_d = lif.line_req_i;
               if (src_ready) begin
                  rdline_a_d   = a_sel;
                  rdline_b_d   = b_sel;
                  weight_d     = w_sel;
                  line_valid_d = 1'b1;
                  pos_d        = pos_q + step_l_q;
                  last_line_d  = is_last;
                  line_cnt_d   = line_cnt_q + 12'd1;
                  state_d      = is_last ? ST_DONE : ST_ACTIVE;
               end else begin
                  // registered so it drops in the same cycle valid rises
                  stall_d = 1'b1;
               end
            end
            default: begin
               // ST_IDLE, ST_DONE
               req_err_d = lif.line_req_i;
            end
         endcase
      end
   end

   always_ff @(posedge VCLK or negedge nRST) begin
      if (!nRST) begin
         state_q      <= ST_IDLE;
         vpos_l_q     <= '0;
         needed_l_q   <= '0;
         vout_l_q     <= '0;
         factor_l_q   <= '0;
         step_l_q     <= '0;
         pos_q        <= '0;
         line_cnt_q   <= '0;
         last_src_q   <= '0;
         line_valid_q <= 1'b0;
         rdline_a_q   <= '0;
         rdline_b_q   <= '0;
         weight_q     <= '0;
         last_line_q  <= 1'b0;
         stall_q      <= 1'b0;
         req_err_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         vpos_l_q     <= vpos_l_d;
         needed_l_q   <= needed_l_d;
         vout_l_q     <= vout_l_d;
         factor_l_q   <= factor_l_d;
         step_l_q     <= step_l_d;
         pos_q        <= pos_d;
         line_cnt_q   <= line_cnt_d;
         last_src_q   <= last_src_d;
         line_valid_q <= line_valid_d;
         rdline_a_q   <= rdline_a_d;
         rdline_b_q   <= rdline_b_d;
         weight_q     <= weight_d;
         last_line_q  <= last_line_d;
         stall_q      <= stall_d;
         req_err_q    <= req_err_d;
      end
   end

   assign lif.line_valid_o = line_valid_q;
   assign lif.rdline_a_o   = rdline_a_q;
   assign lif.rdline_b_o   = rdline_b_q;
   assign lif.weight_o     = weight_q;
   assign lif.last_line_o  = last_line_q;
   assign lif.stall_o      = stall_q;
   assign lif.req_err_o    = req_err_q;

endmodule

// File: tb/tb_scaler_vline_gen.sv
// -----------------------------------------------------------------------------
// tb_scaler_vline_gen
//   Directed bench for scaler_vline_gen: table of per-line expectations for
//   two frame configurations plus hand sequences for stall, priority,
//   degenerate config and mid-frame reset.
// -----------------------------------------------------------------------------
module tb_scaler_vline_gen;

   localparam int S_IDLE   = 0;
   localparam int S_PREP   = 1;
   localparam int S_ACTIVE = 2;
   localparam int S_CHECK  = 3;
   localparam int S_DONE   = 4;
   localparam int LIMIT    = 20;

   logic        VCLK;
   logic        nRST;
   logic        frame_start_i;
   logic [9:0]  vpos_1st_rdline_i;
   logic [9:0]  vlines_in_needed_i;
   logic [11:0] vlines_out_i;
   logic [17:0] v_interp_factor_i;

   scaler_vline_gen_if #(.WGT_W(8)) lif ();

   scaler_vline_gen #(.FRAC_W(17), .WGT_W(8)) dut (
      .VCLK               (VCLK),
      .nRST               (nRST),
      .frame_start_i      (frame_start_i),
      .vpos_1st_rdline_i  (vpos_1st_rdline_i),
      .vlines_in_needed_i (vlines_in_needed_i),
      .vlines_out_i       (vlines_out_i),
      .v_interp_factor_i  (v_interp_factor_i),
      .lif                (lif.slave)
   );

   initial VCLK = 1'b0;
   always #5 VCLK = ~VCLK;

   typedef struct {
      int line;
      int a;
      int b;
      int w;
      int last;
   } vec_t;

   vec_t vecs [10];
   int   n_checks = 0;
   int   n_errors = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge VCLK);
      #1;
   endtask

   task automatic start_frame(input int vpos, input int needed, input int vout, input int factor);
      vpos_1st_rdline_i  = 10'(vpos);
      vlines_in_needed_i = 10'(needed);
      vlines_out_i       = 12'(vout);
      v_interp_factor_i  = 18'(factor);
      frame_start_i      = 1'b1;
      tick();
      frame_start_i      = 1'b0;
      // config is only sampled at frame start; scribble over it afterwards
      vpos_1st_rdline_i  = 10'(vpos + 3);
      vlines_in_needed_i = 10'(needed + 7);
      vlines_out_i       = 12'(vout + 5);
      v_interp_factor_i  = 18'(factor + 11);
      tick();
   endtask

   task automatic request_line(output int lat, output bit ok);
      lif.line_req_i = 1'b1;
      tick();
      lif.line_req_i = 1'b0;
      lat = 0;
      ok  = 1'b0;
      for (int i = 0; i < LIMIT; i++) begin
         @(negedge VCLK);
         lat++;
         if (lif.line_valid_o) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic expect_req_err(input string name);
      lif.line_req_i = 1'b1;
      tick();
      lif.line_req_i = 1'b0;
      @(negedge VCLK);
      chk({name, " req_err"}, int'(lif.req_err_o), 1);
      chk({name, " no valid"}, int'(lif.line_valid_o), 0);
   endtask

   task automatic check_zero(input string name);
      chk({name, " valid"},  int'(lif.line_valid_o), 0);
      chk({name, " a"},      int'(lif.rdline_a_o), 0);
      chk({name, " b"},      int'(lif.rdline_b_o), 0);
      chk({name, " w"},      int'(lif.weight_o), 0);
      chk({name, " last"},   int'(lif.last_line_o), 0);
      chk({name, " stall"},  int'(lif.stall_o), 0);
      chk({name, " req_err"}, int'(lif.req_err_o), 0);
      chk({name, " state"},  int'(dut.state_q), S_IDLE);
      chk({name, " pos"},    int'(dut.pos_q), 0);
   endtask

   task automatic run_frame(input string tag, input int first, input int count,
                            input int nlines, input int max_a);
      int k;
      int top_a;
      int bad_last;
      int lat;
      bit ok;
      k        = first;
      top_a    = 0;
      bad_last = 0;
      for (int ln = 0; ln < nlines; ln++) begin
         request_line(lat, ok);
         if (!ok) begin
            chk($sformatf("%s line %0d timeout", tag, ln), 0, 1);
            return;
         end
         if (ln == 0) chk({tag, " latency"}, lat, 2);
         if (int'(lif.rdline_a_o) > top_a) top_a = int'(lif.rdline_a_o);
         if (int'(lif.last_line_o) != ((ln == nlines - 1) ? 1 : 0)) bad_last++;
         if (k < first + count && vecs[k].line == ln) begin
            chk($sformatf("%s l%0d a", tag, ln), int'(lif.rdline_a_o), vecs[k].a);
            chk($sformatf("%s l%0d b", tag, ln), int'(lif.rdline_b_o), vecs[k].b);
            chk($sformatf("%s l%0d w", tag, ln), int'(lif.weight_o), vecs[k].w);
            chk($sformatf("%s l%0d last", tag, ln), int'(lif.last_line_o), vecs[k].last);
            k++;
         end
      end
      chk({tag, " vectors seen"}, k, first + count);
      chk({tag, " max a"}, top_a, max_a);
      chk({tag, " last_line placement"}, bad_last, 0);
      chk({tag, " end state"}, int'(dut.state_q), S_DONE);
   endtask

   initial begin
      int  lat;
      bit  ok;

      // upscale 240->480, step = 240*273 = 65520
      vecs[0] = '{0,   0,   1,   0,   0};
      vecs[1] = '{1,   0,   1,   127, 0};
      vecs[2] = '{2,   0,   1,   255, 0};
      vecs[3] = '{3,   1,   2,   127, 0};
      vecs[4] = '{479, 239, 239, 113, 1};
      // offset 24, 240->240, step = 240*546 = 131040
      vecs[5] = '{0,   24,  25,  0,   0};
      vecs[6] = '{1,   24,  25,  255, 0};
      vecs[7] = '{16,  39,  40,  255, 0};
      vecs[8] = '{17,  40,  41,  254, 0};
      vecs[9] = '{239, 262, 263, 241, 1};

      nRST                 = 1'b0;
      frame_start_i        = 1'b0;
      vpos_1st_rdline_i    = '0;
      vlines_in_needed_i   = '0;
      vlines_out_i         = '0;
      v_interp_factor_i    = '0;
      lif.line_req_i       = 1'b0;
      lif.lines_avail_i    = '0;
      lif.frame_buffered_i = 1'b0;

      repeat (3) @(negedge VCLK);
      check_zero("reset");
      nRST = 1'b1;
      tick();
      expect_req_err("idle");

      // ---- upscale frame ----
      lif.frame_buffered_i = 1'b1;
      start_frame(0, 240, 480, 273);
      chk("up state active", int'(dut.state_q), S_ACTIVE);
      run_frame("up", 0, 5, 480, 239);
      expect_req_err("up 481st");

      // ---- frame_start + line_req together; also clears last_line ----
      vpos_1st_rdline_i  = 10'd24;
      vlines_in_needed_i = 10'd240;
      vlines_out_i       = 12'd240;
      v_interp_factor_i  = 18'd546;
      frame_start_i      = 1'b1;
      lif.line_req_i     = 1'b1;
      tick();
      frame_start_i      = 1'b0;
      lif.line_req_i     = 1'b0;
      vpos_1st_rdline_i  = 10'd99;
      vlines_out_i       = 12'd7;
      @(negedge VCLK);
      chk("prio state", int'(dut.state_q), S_PREP);
      chk("prio req_err", int'(lif.req_err_o), 0);
      chk("prio valid", int'(lif.line_valid_o), 0);
      chk("prio last cleared", int'(lif.last_line_o), 0);
      @(negedge VCLK);
      chk("prio valid later", int'(lif.line_valid_o), 0);
      chk("prio then active", int'(dut.state_q), S_ACTIVE);

      // ---- offset / clamp frame ----
      run_frame("ofs", 5, 5, 240, 262);

      // ---- stall ----
      lif.frame_buffered_i = 1'b0;
      lif.lines_avail_i    = 10'd1;
      start_frame(0, 240, 480, 273);
      lif.line_req_i = 1'b1;
      tick();
      lif.line_req_i = 1'b0;
      @(negedge VCLK);
      chk("stall cyc1 valid", int'(lif.line_valid_o), 0);
      @(negedge VCLK);
      chk("stall cyc2 stall", int'(lif.stall_o), 1);
      chk("stall cyc2 valid", int'(lif.line_valid_o), 0);
      lif.line_req_i = 1'b1;
      tick();
      lif.line_req_i = 1'b0;
      @(negedge VCLK);
      chk("stall req_err", int'(lif.req_err_o), 1);
      chk("stall still", int'(lif.stall_o), 1);
      chk("stall valid", int'(lif.line_valid_o), 0);
      chk("stall state", int'(dut.state_q), S_CHECK);
      lif.lines_avail_i = 10'd2;
      @(negedge VCLK);
      chk("release valid", int'(lif.line_valid_o), 1);
      chk("release stall", int'(lif.stall_o), 0);
      chk("release a", int'(lif.rdline_a_o), 0);
      chk("release b", int'(lif.rdline_b_o), 1);
      chk("release w", int'(lif.weight_o), 0);

      // ---- frame_start during a stall ----
      lif.lines_avail_i = 10'd1;
      start_frame(5, 240, 480, 273);
      lif.line_req_i = 1'b1;
      tick();
      lif.line_req_i = 1'b0;
      repeat (2) @(negedge VCLK);
      chk("abort stalled", int'(lif.stall_o), 1);
      vpos_1st_rdline_i  = 10'd7;
      vlines_in_needed_i = 10'd240;
      vlines_out_i       = 12'd480;
      v_interp_factor_i  = 18'd273;
      frame_start_i      = 1'b1;
      tick();
      frame_start_i      = 1'b0;
      @(negedge VCLK);
      chk("abort state", int'(dut.state_q), S_PREP);
      chk("abort stall", int'(lif.stall_o), 0);
      chk("abort valid", int'(lif.line_valid_o), 0);
      @(negedge VCLK);
      chk("abort active", int'(dut.state_q), S_ACTIVE);
      chk("abort pos", int'(dut.pos_q), 7 * 131072);
      lif.frame_buffered_i = 1'b1;
      request_line(lat, ok);
      chk("abort ok", int'(ok), 1);
      chk("abort lat", lat, 2);
      chk("abort a", int'(lif.rdline_a_o), 7);
      chk("abort b", int'(lif.rdline_b_o), 8);
      chk("abort w", int'(lif.weight_o), 0);

      // ---- degenerate vlines_out = 0 ----
      start_frame(0, 10, 0, 0);
      chk("degen state", int'(dut.state_q), S_DONE);
      expect_req_err("degen 1");
      expect_req_err("degen 2");

      // ---- mid-frame reset after 10 lines ----
      start_frame(0, 240, 480, 273);
      for (int i = 0; i < 10; i++) begin
         request_line(lat, ok);
         if (!ok) chk($sformatf("rst prefill %0d timeout", i), 0, 1);
      end
      chk("rst prefill a", int'(lif.rdline_a_o), 4);
      chk("rst prefill w", int'(lif.weight_o), 127);
      @(posedge VCLK);
      #3;
      nRST = 1'b0;
      #1;
      check_zero("midrst");
      chk("midrst line_cnt", int'(dut.line_cnt_q), 0);
      @(negedge VCLK);
      nRST = 1'b1;
      expect_req_err("post rst 1");
      expect_req_err("post rst 2");
      start_frame(0, 240, 480, 273);
      request_line(lat, ok);
      chk("post rst ok", int'(ok), 1);
      chk("post rst a", int'(lif.rdline_a_o), 0);
      chk("post rst b", int'(lif.rdline_b_o), 1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global timeout: got running expected finished");
      $fatal(1);
   end

endmodule
